// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, BAUD_END sclk cycles per bit.
// Accepts a byte on a one-cycle tx_trig pulse while idle; tx_busy covers the frame and tx_done.
module uart_tx #(
  parameter int BAUD_END = 5208,
  parameter int BIT_END  = 10
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       tx_trig,
  input  logic [7:0] tx_data,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BW = (BAUD_END > 2) ? $clog2(BAUD_END) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic            work_en;
  logic            bit_flag;
  logic [BW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      tx_data_r;

  logic [3:0]      bit_nxt;
  logic [2:0]      bit_idx;
  logic            line_nxt;

  // The line register looks at the bit index it is about to move to, so the
  // line changes on the same edge as bit_cnt and every bit is exactly BAUD_END.
  always_comb begin
    bit_nxt  = bit_flag ? bit_cnt + 4'd1 : bit_cnt;
    bit_idx  = 3'(bit_nxt - 4'd1);
    line_nxt = 1'b1;
    if (bit_nxt == 4'd0)      line_nxt = 1'b0;
    else if (bit_nxt <= 4'd8) line_nxt = tx_data_r[bit_idx];
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      work_en   <= 1'b0;
      bit_flag  <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_data_r <= '0;
      rs232_tx  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      bit_flag <= work_en && (baud_cnt == BW'(BAUD_END - 1));
      baud_cnt <= (work_en && baud_cnt != BW'(BAUD_END - 1)) ? baud_cnt + BW'(1) : '0;
      rs232_tx <= work_en ? line_nxt : 1'b1;
      case (state)
        IDLE: begin
          if (tx_trig) begin
            tx_data_r <= tx_data;
            work_en   <= 1'b1;
            tx_busy   <= 1'b1;
            bit_cnt   <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (work_en) begin
            if (bit_flag) begin
              if (bit_cnt == 4'(BIT_END - 1)) begin
                bit_cnt <= '0;
                work_en <= 1'b0;
                tx_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            // Stay busy through the tx_done cycle so a trigger there is dropped.
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with a shortened bit period; line, busy and done are captured per cycle
// and compared with a time-indexed frame model and a mid-bit sampling receiver.
module tb_uart_tx;
  localparam int B  = 16;
  localparam int NB = 10;
  localparam int FL = B * NB;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       tx_trig = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rs232_tx, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;

  logic cap_line[$];
  logic cap_busy[$];
  logic cap_done[$];

  uart_tx #(.BAUD_END(B), .BIT_END(NB)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .tx_trig(tx_trig), .tx_data(tx_data),
    .rs232_tx(rs232_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 sclk = ~sclk;

  // k counts rising edges after the edge that accepted the trigger.
  // Start bit occupies k=1..B, data bit n occupies the n-th B-cycle slot after it.
  function automatic logic exp_line(input logic [7:0] d, input int k);
    int n;
    if (k < 1 || k > FL) return 1'b1;
    n = (k - 1) / B;
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    return 1'b1;
  endfunction

  function automatic int line_errs(input logic [7:0] d1, input bit two, input logic [7:0] d2, input int off);
    int e = 0;
    logic x;
    for (int k = 0; k < cap_line.size(); k++) begin
      x = exp_line(d1, k) & (two ? exp_line(d2, k - off) : 1'b1);
      if (cap_line[k] !== x) e++;
    end
    return e;
  endfunction

  // Busy spans the accept edge through the tx_done cycle: k = 0..FL+1.
  function automatic int busy_errs(input bit first, input bit two, input int off);
    int e = 0;
    logic x;
    for (int k = 0; k < cap_busy.size(); k++) begin
      x = (first && k <= FL + 1) || (two && k >= off && k - off <= FL + 1);
      if (cap_busy[k] !== x) e++;
    end
    return e;
  endfunction

  function automatic int done_count();
    int c = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int done_at();
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) return i;
    return -1;
  endfunction

  // Receiver model: find a falling edge, sample each bit at its centre.
  function automatic logic [8:0] rx_decode(input int from);
    int s = -1;
    int idx;
    logic [7:0] d = 8'h00;
    for (int i = from; i < cap_line.size(); i++)
      if (cap_line[i] === 1'b0) begin s = i; break; end
    if (s < 0) return 9'h000;
    for (int j = 0; j < NB; j++) begin
      idx = s + B/2 + j*B;
      if (idx >= cap_line.size()) return 9'h000;
      if (j == 0 && cap_line[idx] !== 1'b0) return 9'h000;
      if (j == NB-1 && cap_line[idx] !== 1'b1) return 9'h000;
      if (j >= 1 && j <= 8) d[j-1] = cap_line[idx];
    end
    return {1'b1, d};
  endfunction

  task automatic start(input logic [7:0] d);
    @(posedge sclk); #1;
    tx_trig = 1'b1; tx_data = d;
    @(posedge sclk); #1;
    tx_trig = 1'b0; tx_data = 8'($urandom);
  endtask

  // Records n samples; optionally pulses tx_trig so it is seen at edge k=inj_k+1.
  task automatic capture(input int n, input int inj_k, input logic [7:0] inj_d);
    cap_line.delete(); cap_busy.delete(); cap_done.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge sclk);
      cap_line.push_back(rs232_tx);
      cap_busy.push_back(tx_busy);
      cap_done.push_back(tx_done);
      tx_trig = (k == inj_k);
      tx_data = (k == inj_k) ? inj_d : 8'($urandom);
    end
    @(negedge sclk);
    tx_trig = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    s_rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    checks++;
    if ({rs232_tx, tx_busy, tx_done} !== 3'b100)
      begin failures++; $display("FAIL reset_outputs got=%b want=100", {rs232_tx, tx_busy, tx_done}); end
    @(negedge sclk) s_rst_n = 1'b1;
    capture(2000, -1, 8'h00);
    e = 0;
    foreach (cap_line[i]) if (cap_line[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) e++;
    checks++;
    if (e !== 0) begin failures++; $display("FAIL idle_quiet bad_cycles=%0d want=0", e); end
  endtask

  task automatic test_frame(input string nm, input logic [7:0] d);
    logic [8:0] r;
    int e;
    start(d);
    capture(FL + 8, -1, 8'h00);
    e = line_errs(d, 1'b0, 8'h00, 0);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL %s_line d=%h bad_cycles=%0d want=0", nm, d, e); end
    checks++;
    if (done_count() !== 1 || done_at() !== FL + 1)
      begin failures++; $display("FAIL %s_done count=%0d at=%0d want=1 at %0d", nm, done_count(), done_at(), FL + 1); end
    e = busy_errs(1'b1, 1'b0, 0);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL %s_busy bad_cycles=%0d want=0", nm, e); end
    r = rx_decode(0);
    checks++;
    if (r !== {1'b1, d}) begin failures++; $display("FAIL %s_rx got=%h want=%h", nm, r, {1'b1, d}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) test_frame("rand", 8'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [8:0] r;
    int e, s, run;
    start(8'h00);
    capture(2*FL + 12, FL + 2, 8'hFF);
    e = line_errs(8'h00, 1'b1, 8'hFF, FL + 3);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL b2b_line bad_cycles=%0d want=0", e); end
    e = busy_errs(1'b1, 1'b1, FL + 3);
    checks++;
    if (e !== 0 || done_count() !== 2)
      begin failures++; $display("FAIL b2b_busy_done bad=%0d dones=%0d want=0,2", e, done_count()); end
    r = rx_decode(0);
    checks++;
    if (r !== 9'h100) begin failures++; $display("FAIL b2b_rx0 got=%h want=100", r); end
    r = rx_decode(FL + 1);
    checks++;
    if (r !== 9'h1FF) begin failures++; $display("FAIL b2b_rx1 got=%h want=1ff", r); end
    s = -1;
    for (int i = FL; i < cap_line.size(); i++) if (cap_line[i] === 1'b0) begin s = i; break; end
    run = 0;
    for (int i = s - 1; i >= 0 && cap_line[i] === 1'b1; i--) run++;
    checks++;
    if (s < 0 || run < B) begin failures++; $display("FAIL b2b_stop_gap start=%0d run=%0d want>=%0d", s, run, B); end
  endtask

  task automatic test_trig_on_done();
    int e;
    start(8'h5A);
    capture(FL + 3*B, FL + 1, 8'h00);
    e = line_errs(8'h5A, 1'b0, 8'h00, 0) + busy_errs(1'b1, 1'b0, 0);
    checks++;
    if (e !== 0 || done_count() !== 1)
      begin failures++; $display("FAIL done_trig_ignored bad=%0d dones=%0d want=0,1", e, done_count()); end
  endtask

  task automatic test_ignore_busy();
    logic [8:0] r;
    int e;
    start(8'h12);
    capture(FL + 3*B, 3*B + 5, 8'h34);
    e = line_errs(8'h12, 1'b0, 8'h00, 0) + busy_errs(1'b1, 1'b0, 0);
    checks++;
    if (e !== 0 || done_count() !== 1)
      begin failures++; $display("FAIL busy_trig_ignored bad=%0d dones=%0d want=0,1", e, done_count()); end
    r = rx_decode(0);
    checks++;
    if (r !== 9'h112) begin failures++; $display("FAIL busy_trig_rx got=%h want=112", r); end
  endtask

  task automatic test_reset_mid();
    int e;
    start(8'hF0);
    capture(4*B + B/2, -1, 8'h00);
    s_rst_n = 1'b0;
    #1;
    checks++;
    if ({rs232_tx, tx_busy, tx_done} !== 3'b100)
      begin failures++; $display("FAIL midreset_async got=%b want=100", {rs232_tx, tx_busy, tx_done}); end
    @(negedge sclk);
    @(negedge sclk) s_rst_n = 1'b1;
    capture(3*B, -1, 8'h00);
    e = 0;
    foreach (cap_line[i]) if (cap_line[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) e++;
    checks++;
    if (e !== 0) begin failures++; $display("FAIL midreset_idle bad_cycles=%0d want=0", e); end
    test_frame("after_rst", 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_frame("x55", 8'h55);
    test_frame("xA3", 8'hA3);
    test_random();
    test_back_to_back();
    test_trig_on_done();
    test_ignore_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; companion to the team's UART receiver on the same rs232 link.
- Serialises one byte per request: start bit (0), 8 data bits LSB first, stop bit (1), at a fixed baud set by clock divisor.
- Sits between the command/readback datapath (e.g. SDRAM read data path) and the board rs232_tx pin; accepts bytes via a single-cycle pulse interface and reports busy/done.

Parameters:
- BAUD_END, 5208, sclk cycles per bit (50 MHz / 9600 baud).
- BIT_END, 10, bits per frame including start and stop.

Ports:
- sclk  input  1  system clock, all logic on rising edge.
- s_rst_n  input  1  asynchronous active-low reset.
- tx_trig  input  1  single-cycle request pulse; sample tx_data this cycle.
- tx_data  input  8  byte to send, valid when tx_trig=1.
- rs232_tx  output  1  serial line out, idle high.
- tx_busy  output  1  high while a frame is in progress (request accepted, not yet finished).
- tx_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Clock/reset: one clock sclk; reset asynchronous, active-low on s_rst_n; all flops registered, no latches.
- Reset values: rs232_tx=1, tx_busy=0, tx_done=0, internal counters=0, data latch=0, state=IDLE.
- States: IDLE -> SEND -> IDLE. No other states.
- IDLE: rs232_tx=1. On tx_trig=1: latch tx_data into tx_data_r, set work_en (tx_busy)=1 next cycle, enter SEND.
- tx_trig while busy: ignored; latched byte unchanged, frame unaffected, no error flag.
- baud_cnt (13 bit): counts 0..BAUD_END-1 while work_en=1, wraps to 0; held at 0 when work_en=0.
- bit_flag: registered pulse, high one cycle when baud_cnt==BAUD_END-1 (bit boundary).
- bit_cnt (4 bit): increments on bit_flag while work_en; range 0..BIT_END-1.
- rs232_tx driven from register: bit_cnt 0 -> 0 (start); bit_cnt 1..8 -> tx_data_r[bit_cnt-1]; bit_cnt 9 -> 1 (stop).
- Latency: rs232_tx falls 2 sclk cycles after the tx_trig cycle (latch + output register); each bit lasts exactly BAUD_END cycles, ±0.
- Frame end: when bit_flag=1 and bit_cnt==BIT_END-1: bit_cnt->0, work_en->0, tx_done pulses 1 cycle, rs232_tx stays 1.
- Total frame length: BIT_END*BAUD_END cycles of line time; tx_busy high for that duration (±1 cycle for register alignment, fixed and documented by bench).
- Back-to-back: tx_trig accepted the cycle after tx_done (tx_busy=0); next start bit then follows with no idle gap beyond the 2-cycle latency.
- tx_trig coincident with tx_done cycle: ignored (busy still 1 in that cycle).
- Reset mid-frame: line returns to 1 immediately (async), all state cleared; no partial bits resumed after reset release.
- tx_data sampled only on accepted tx_trig; changes at other times have no effect.

Test Plan:
- Reset then idle 20000 cycles, no trig -> rs232_tx=1, tx_busy=0, tx_done never asserted.
- tx_trig with tx_data=8'h55 -> line 0,1,0,1,0,1,0,1,0,1 each 5208 cycles; one tx_done pulse; tx_busy=0 after.
- tx_data=8'hA3 loopback into team uart_rx -> receiver po_flag once, po_data=8'hA3.
- Send 8'h00 then 8'hFF with trig the cycle after tx_done -> both bytes decoded correctly, stop bit high ≥5208 cycles between frames.
- tx_trig with 8'h12 then second tx_trig 8'h34 mid-frame -> only 8'h12 transmitted, one tx_done.
- Assert s_rst_n=0 during bit 4 of 8'hF0 -> rs232_tx=1 and tx_busy=0 within same cycle; after release line stays idle until new trig.
